alarm_controller: RTL and testbench

- Sits directly downstream of the mode picker; consumes its 4-bit one-hot field select and its enable.
- Edits the stored alarm time and arm flag from debounced up/down pulses.
- Compares the stored alarm against the running clock time and runs the ring/snooze state machine that drives the buzzer and LED outputs.

---
 rtl/alarm_controller_pkg.sv | 20 ++
 rtl/alarm_controller_wrap.sv | 37 +++
 rtl/alarm_controller.sv | 151 +++++++++++++++
 tb/tb_alarm_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the alarm controller: FSM encoding, field-select
// indices and time/counter limits.
package alarm_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZED = 2'd3
  } alarm_state_e;

  localparam int SEL_MIN  = 0;
  localparam int SEL_HOUR = 1;
  localparam int SEL_ARM  = 2;

  localparam int MAX_MIN  = 59;
  localparam int MAX_HOUR = 23;
  localparam int CNT_W    = 9;

endpackage

// File: rtl/alarm_controller_wrap.sv
// Modular up/down counter wrapping between 0 and MAX; steps only when
// load_en is high and exactly one of up/down is asserted.
module wrap_updown_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_en && up && !down) begin
      value_d = (value_q == W'(MAX)) ? '0 : value_q + 1'b1;
    end else if (load_en && down && !up) begin
      value_d = (value_q == '0) ? W'(MAX) : value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm time/arm editing plus the match-edge detector and the
// ring/snooze state machine driving the buzzer and LED outputs.
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] sel,
  input  logic       inc,
  input  logic       dec,
  input  logic       stop,
  input  logic       snooze,
  input  logic       sec_tick,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       armed,
  output logic       ringing,
  output logic       snoozing
);

  alarm_state_e     state_q, state_d;
  logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
  logic             match_q, match_d;

  logic sel_onehot;
  logic edit_ok;
  logic min_edit;
  logic hour_edit;
  logic arm_toggle;
  logic match;
  logic trigger;

  assign sel_onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign edit_ok    = en && sel_onehot && (inc ^ dec);
  assign min_edit   = edit_ok && sel[SEL_MIN];
  assign hour_edit  = edit_ok && sel[SEL_HOUR];
  assign arm_toggle = edit_ok && sel[SEL_ARM];

  wrap_updown_counter #(.W(6), .MAX(MAX_MIN)) u_min_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_en (min_edit),
    .up      (inc),
    .down    (dec),
    .value   (alarm_min)
  );

  wrap_updown_counter #(.W(5), .MAX(MAX_HOUR)) u_hour_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_en (hour_edit),
    .up      (inc),
    .down    (dec),
    .value   (alarm_hour)
  );

  // match_q follows match even during edits so dropping en cannot fake an edge.
  assign match   = (cur_hour == alarm_hour) && (cur_min == alarm_min);
  assign match_d = match;
  assign trigger = match && !match_q && !en;

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;

    case (state_q)
      IDLE: begin
        if (arm_toggle) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        if (arm_toggle) begin
          state_d      = IDLE;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end else if (trigger) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
        end
      end

      RINGING: begin
        if (sec_tick) begin
          ring_cnt_d = ring_cnt_q + 1'b1;
        end
        if (arm_toggle) begin
          state_d      = IDLE;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end else if (stop) begin
          state_d = ARMED;
        end else if (snooze) begin
          state_d      = SNOOZED;
          snooze_cnt_d = '0;
        end else if (sec_tick && ring_cnt_q == CNT_W'(RING_SECS - 1)) begin
          state_d = ARMED;
        end
      end

      SNOOZED: begin
        if (sec_tick) begin
          snooze_cnt_d = snooze_cnt_q + 1'b1;
        end
        if (arm_toggle) begin
          state_d      = IDLE;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end else if (stop) begin
          state_d = ARMED;
        end else if (sec_tick && snooze_cnt_q == CNT_W'(SNOOZE_SECS - 1)) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      match_q      <= match_d;
    end
  end

  // Outputs decode directly from the registered state.
  assign armed    = (state_q != IDLE);
  assign ringing  = (state_q == RINGING);
  assign snoozing = (state_q == SNOOZED);

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller: edit wrap, trigger,
// auto-silence, snooze, priority, edit suppression and async reset.
module tb_alarm_controller;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] sel;
  logic       inc;
  logic       dec;
  logic       stop;
  logic       snooze;
  logic       sec_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       armed;
  logic       ringing;
  logic       snoozing;

  int checks;
  int failures;

  alarm_controller #(.RING_SECS(60), .SNOOZE_SECS(300)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sel        (sel),
    .inc        (inc),
    .dec        (dec),
    .stop       (stop),
    .snooze     (snooze),
    .sec_tick   (sec_tick),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .armed      (armed),
    .ringing    (ringing),
    .snoozing   (snoozing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic pulse_inc();
    inc = 1'b1; step(); inc = 1'b0;
  endtask

  task automatic pulse_dec();
    dec = 1'b1; step(); dec = 1'b0;
  endtask

  task automatic tick();
    sec_tick = 1'b1; step(); sec_tick = 1'b0; step();
  endtask

  task automatic chk_state(input string tag, input logic a, input logic r, input logic s);
    chk({tag, ".armed"},    32'(armed),    32'(a));
    chk({tag, ".ringing"},  32'(ringing),  32'(r));
    chk({tag, ".snoozing"}, 32'(snoozing), 32'(s));
  endtask

  // Step cur time off the alarm then back onto 07:30 to produce a fresh match edge.
  task automatic retrigger_0730();
    cur_hour = 5'd7; cur_min = 6'd31; step();
    cur_min = 6'd30; step();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; sel = 4'd0; inc = 1'b0; dec = 1'b0;
    stop = 1'b0; snooze = 1'b0; sec_tick = 1'b0;
    cur_hour = 5'd0; cur_min = 6'd0;
    repeat (3) step();
    rst = 1'b0; step();
    chk("reset.alarm_hour", 32'(alarm_hour), 32'd0);
    chk("reset.alarm_min",  32'(alarm_min),  32'd0);
    chk_state("reset", 1'b0, 1'b0, 1'b0);

    // Minute and hour wrap
    cur_hour = 5'd12; cur_min = 6'd0;
    en = 1'b1; sel = 4'b0001;
    pulse_dec(); chk("min.dec_wrap0", 32'(alarm_min), 32'd59);
    pulse_inc(); chk("min.inc_wrap59", 32'(alarm_min), 32'd0);
    pulse_dec(); chk("min.dec_again", 32'(alarm_min), 32'd59);
    sel = 4'b0010;
    pulse_dec(); chk("hour.dec_wrap0", 32'(alarm_hour), 32'd23);
    pulse_inc(); chk("hour.inc_wrap23", 32'(alarm_hour), 32'd0);
    inc = 1'b1; dec = 1'b1; step(); inc = 1'b0; dec = 1'b0;
    chk("hour.inc_dec_both", 32'(alarm_hour), 32'd0);
    sel = 4'b0011; pulse_inc();
    chk("multihot.hour", 32'(alarm_hour), 32'd0);
    chk("multihot.min",  32'(alarm_min),  32'd59);
    sel = 4'b0000; pulse_inc();
    chk("sel0.min", 32'(alarm_min), 32'd59);
    sel = 4'b1000; pulse_inc();
    chk("sel3.min", 32'(alarm_min), 32'd59);
    chk_state("sel3", 1'b0, 1'b0, 1'b0);

    // Program 07:30 and arm
    sel = 4'b0010;
    for (int i = 0; i < 7; i++) pulse_inc();
    sel = 4'b0001;
    for (int i = 0; i < 31; i++) pulse_inc();
    chk("set.hour", 32'(alarm_hour), 32'd7);
    chk("set.min",  32'(alarm_min),  32'd30);
    sel = 4'b0100; pulse_inc();
    chk_state("arm", 1'b1, 1'b0, 1'b0);

    // Trigger on 07:29 -> 07:30 edge, then auto-silence after 60 ticks
    en = 1'b0; sel = 4'b0000;
    cur_hour = 5'd7; cur_min = 6'd29; step(); step();
    chk("pre_trigger.ringing", 32'(ringing), 32'd0);
    cur_min = 6'd30; step();
    chk_state("trigger", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 59; i++) tick();
    chk("ring59.ringing", 32'(ringing), 32'd1);
    tick();
    chk_state("auto_silence", 1'b1, 1'b0, 1'b0);
    repeat (5) step();
    chk("hold_match.ringing", 32'(ringing), 32'd0);

    // Snooze for 300 ticks, resume, then stop
    retrigger_0730();
    chk("retrigger.ringing", 32'(ringing), 32'd1);
    snooze = 1'b1; step(); snooze = 1'b0;
    chk_state("snooze", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 299; i++) tick();
    chk("snooze299.snoozing", 32'(snoozing), 32'd1);
    tick();
    chk_state("snooze_expire", 1'b1, 1'b1, 1'b0);
    stop = 1'b1; step(); stop = 1'b0;
    chk_state("stop", 1'b1, 1'b0, 1'b0);

    // Priority: stop beats snooze; arm toggle beats snooze
    retrigger_0730();
    chk("prio1.ringing", 32'(ringing), 32'd1);
    stop = 1'b1; snooze = 1'b1; step(); stop = 1'b0; snooze = 1'b0;
    chk_state("stop_vs_snooze", 1'b1, 1'b0, 1'b0);
    retrigger_0730();
    chk("prio2.ringing", 32'(ringing), 32'd1);
    en = 1'b1; sel = 4'b0100; inc = 1'b1; snooze = 1'b1; step();
    inc = 1'b0; snooze = 1'b0;
    chk_state("arm_vs_snooze", 1'b0, 1'b0, 1'b0);

    // Edit suppression: move alarm onto current minute while en=1
    pulse_inc();
    chk_state("rearm", 1'b1, 1'b0, 1'b0);
    cur_hour = 5'd7; cur_min = 6'd45;
    sel = 4'b0001;
    for (int i = 0; i < 15; i++) pulse_inc();
    chk("edit.min", 32'(alarm_min), 32'd45);
    step();
    chk("edit.no_ring", 32'(ringing), 32'd0);
    en = 1'b0; sel = 4'b0000;
    repeat (4) step();
    chk_state("edit_release", 1'b1, 1'b0, 1'b0);

    // Async reset while ringing, then no ring at 00:00
    cur_min = 6'd44; step();
    cur_min = 6'd45; step();
    chk("pre_reset.ringing", 32'(ringing), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.alarm_hour", 32'(alarm_hour), 32'd0);
    chk("async_rst.alarm_min",  32'(alarm_min),  32'd0);
    chk_state("async_rst", 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    cur_hour = 5'd23; cur_min = 6'd59; step();
    cur_hour = 5'd0;  cur_min = 6'd0;  step(); step();
    chk_state("post_reset_0000", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
